neighbour_scanner: RTL and testbench
====================================

// Module: neighbour_scanner
// PURPOSE
// - Upstream feeder for the Life rule stage. Holds the current generation
//   (MAX_J+1 rows x MAX_I+1 cols). On each step it streams every cell
//   row-major as (x, y, alive, sum_neighbours) to the rule stage.
// - Collects the rule stage's in-order next-state results into a shadow
//   grid, then commits the shadow grid as the new generation.
// - Provides a combinational read port for the VGA pixel path and a seed write port.
// PARAMETERS
// - MAX_I  19  last column index (20 columns)
// - MAX_J  14  last row index (15 rows)
// - WRAP    0  1 = toroidal neighbourhood; 0 = off-grid neighbours count as dead
// PORTS
// - clk           in   1  system clock
// - clr           in   1  asynchronous, active-low reset
// - step          in   1  1-cycle pulse: start one generation (honoured only in IDLE)
// - wr_en         in   1  seed write strobe (honoured only in IDLE)
// - wr_x, wr_y    in   5,4  seed cell coordinates
// - wr_alive      in   1  seed value
// - rd_x, rd_y    in   5,4  display lookup coordinates (VGAx[9:5], VGAy[8:5])
// - rd_alive      out  1  current-generation state at (rd_x, rd_y), combinational
// - cell_valid    out  1  cell_* outputs valid
// - cell_ready    in   1  rule stage accepts the cell
// - cell_x        out  5  column of the emitted cell
// - cell_y        out  4  row of the emitted cell
// - cell_alive    out  1  current state of the emitted cell
// - sum_neighbours out 4  live-neighbour count, 0..8
// - res_valid     in   1  rule stage result strobe; results return in emission order
// - res_alive     in   1  next state for the oldest outstanding cell
// - busy          out  1  high outside IDLE
// - gen_done      out  1  1-cycle pulse in the cycle after COMMIT
// BEHAVIOUR
// - Reset: both grids all 0; state IDLE; cell_valid = 0, busy = 0,
//   gen_done = 0; cell_x/cell_y = 0; emit and result counters = 0.
// - IDLE:
//   - wr_en writes grid[wr_y][wr_x] next edge.
//   - Out-of-range coordinates (x > MAX_I or y > MAX_J) are ignored.
//   - step moves to SCAN. If step and wr_en coincide, the write lands first, then SCAN.
// - SCAN:
//   - cell_valid = 1. Transfer occurs when cell_valid & cell_ready.
//   - cell_x/cell_y advance row-major on each transfer: x wraps MAX_I -> 0 and y increments.
//   - The transfer of (MAX_I, MAX_J) moves to DRAIN.
//   - Outputs hold stable while cell_ready = 0.
// - sum_neighbours:
//   - 4-bit sum of the 8 neighbours of the emitted cell, read from the current grid.
//   - WRAP = 0: indices -1 or >MAX read as 0. WRAP = 1: indices are taken mod row/col count.
// - Results:
//   - res_valid is legal in SCAN and DRAIN.
//   - Each res_valid writes res_alive to shadow at the result counter's (x, y),
//     then advances that counter row-major.
//   - A result may arrive in the same cycle as a transfer.
//   - res_valid in IDLE is ignored.
// - DRAIN: cell_valid = 0. The final result (result counter wraps past (MAX_I, MAX_J)) moves to COMMIT.
// - COMMIT (1 cycle): grid <= shadow, then IDLE with gen_done = 1 for one cycle.
// - busy = 1 in SCAN, DRAIN and COMMIT. step while busy is ignored, not queued.
// - rd_alive:
//   - Always reflects the committed grid; it never shows a partial generation.
//   - Returns 0 for out-of-range rd coordinates (e.g. rd_x 20..31).
// - clr mid-operation: immediate return to reset state. Any partial shadow is discarded.
// STRUCTURE
// - Shared package life_pkg: MAX_I/MAX_J defaults, coordinate widths (5/4),
//   neighbour-count width (4), scanner state encoding (IDLE/SCAN/DRAIN/COMMIT).
// - One sub-module: neighbour_sum. Combinational 3x3 window adder over the grid
//   with the edge/WRAP policy; inputs are the grid and (x, y), output is a 4-bit sum.
// - Grids are flat registers; no RAM inference (needs a 9-cell parallel read).
// TESTING
// - Reset: assert clr=0 mid-SCAN
//   -> busy=0, cell_valid=0, rd_alive=0 everywhere, next step starts at (0,0).
// - Blinker: seed (5,4),(6,4),(7,4); step with cell_ready=1; bench echoes the
//   Life rule -> sum at (6,3)=3, (6,4)=2; after gen_done alive = (6,3),(6,4),(6,5) only.
// - Edges, WRAP=0: seed all four corners -> sum at (0,0)=0, (MAX_I,MAX_J)=0.
//   WRAP=1: (0,0) sum=3.
// - Backpressure: random cell_ready at 30% duty -> exactly 300 transfers, no
//   duplicate or skipped coordinates, outputs stable while stalled.
// - Result lag: delay res_valid up to 20 cycles behind transfers ->
//   DRAIN waits; gen_done fires once, exactly 1 cycle after the 300th result.
// - Protocol: step while busy, wr_en while busy, out-of-range wr_x=25
//   -> all ignored; grid unchanged; rd_x=25 returns 0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared Life-engine constants, scanner state encoding and flat grid indexing.
package life_pkg;

  localparam int MAX_I_DEF = 19;
  localparam int MAX_J_DEF = 14;
  localparam int X_W       = 5;
  localparam int Y_W       = 4;
  localparam int SUM_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_COMMIT
  } scan_state_e;

  // Grids are stored row-major: bit y*cols + x holds cell (x, y).
  function automatic int flat_idx(input int x, input int y, input int cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/neighbour_sum.sv
// Combinational 3x3 live-neighbour adder over a flat grid.
// Off-grid neighbours read as dead unless WRAP folds them onto the opposite edge.
module neighbour_sum
  import life_pkg::*;
#(
  parameter int MAX_I = MAX_I_DEF,
  parameter int MAX_J = MAX_J_DEF,
  parameter bit WRAP  = 1'b0
) (
  input  logic [(MAX_I+1)*(MAX_J+1)-1:0] grid,
  input  logic [X_W-1:0]                 x,
  input  logic [Y_W-1:0]                 y,
  output logic [SUM_W-1:0]               sum
);

  localparam int COLS  = MAX_I + 1;
  localparam int ROWS  = MAX_J + 1;
  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);

  int               nx;
  int               ny;
  logic [IDX_W-1:0] idx;

  always_comb begin
    sum = '0;
    nx  = 0;
    ny  = 0;
    idx = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          nx = int'(x) + dx;
          ny = int'(y) + dy;
          if (WRAP) begin
            if (nx < 0) nx = nx + COLS;
            else if (nx > MAX_I) nx = nx - COLS;
            if (ny < 0) ny = ny + ROWS;
            else if (ny > MAX_J) ny = ny - ROWS;
          end
          if (nx >= 0 && nx <= MAX_I && ny >= 0 && ny <= MAX_J) begin
            idx = IDX_W'(flat_idx(nx, ny, COLS));
            sum = sum + SUM_W'(grid[idx]);
          end
        end
      end
    end
  end

endmodule

// File: rtl/neighbour_scanner.sv
// Life generation sequencer: streams cells with neighbour counts to the rule
// stage, gathers in-order results into a shadow grid and commits them atomically.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | grid stable; seed writes and step accepted
// S_SCAN   | emitting cells row-major, results may already be returning
// S_DRAIN  | all cells sent, waiting for the remaining results
// S_COMMIT | shadow copied into the current grid, gen_done follows
module neighbour_scanner
  import life_pkg::*;
#(
  parameter int MAX_I = MAX_I_DEF,
  parameter int MAX_J = MAX_J_DEF,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             step,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic             wr_alive,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_alive,
  output logic             cell_valid,
  input  logic             cell_ready,
  output logic [X_W-1:0]   cell_x,
  output logic [Y_W-1:0]   cell_y,
  output logic             cell_alive,
  output logic [SUM_W-1:0] sum_neighbours,
  input  logic             res_valid,
  input  logic             res_alive,
  output logic             busy,
  output logic             gen_done
);

  localparam int COLS  = MAX_I + 1;
  localparam int CELLS = COLS * (MAX_J + 1);
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [X_W-1:0] LAST_X = X_W'(MAX_I);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(MAX_J);

  scan_state_e      state;
  logic [CELLS-1:0] grid;
  logic [CELLS-1:0] shadow;
  logic [X_W-1:0]   res_x;
  logic [Y_W-1:0]   res_y;

  logic             wr_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] cell_idx;
  logic [IDX_W-1:0] res_idx;
  logic             xfer;
  logic             cell_last;
  logic             res_last;

  assign wr_in_range = (wr_x <= LAST_X) && (wr_y <= LAST_Y);
  assign rd_in_range = (rd_x <= LAST_X) && (rd_y <= LAST_Y);
  assign wr_idx      = IDX_W'(flat_idx(int'(wr_x), int'(wr_y), COLS));
  assign rd_idx      = IDX_W'(flat_idx(int'(rd_x), int'(rd_y), COLS));
  assign cell_idx    = IDX_W'(flat_idx(int'(cell_x), int'(cell_y), COLS));
  assign res_idx     = IDX_W'(flat_idx(int'(res_x), int'(res_y), COLS));

  // Display only ever sees the committed grid; the shadow is never visible.
  assign rd_alive   = rd_in_range & grid[rd_idx];
  assign cell_alive = grid[cell_idx];

  assign xfer      = cell_valid & cell_ready;
  assign cell_last = (cell_x == LAST_X) && (cell_y == LAST_Y);
  assign res_last  = (res_x == LAST_X) && (res_y == LAST_Y);

  neighbour_sum #(
    .MAX_I (MAX_I),
    .MAX_J (MAX_J),
    .WRAP  (WRAP)
  ) u_neighbour_sum (
    .grid (grid),
    .x    (cell_x),
    .y    (cell_y),
    .sum  (sum_neighbours)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_IDLE;
      grid       <= '0;
      shadow     <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      res_x      <= '0;
      res_y      <= '0;
      cell_valid <= 1'b0;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (wr_en && wr_in_range) grid[wr_idx] <= wr_alive;
          if (step) begin
            state      <= S_SCAN;
            cell_valid <= 1'b1;
            busy       <= 1'b1;
            cell_x     <= '0;
            cell_y     <= '0;
            res_x      <= '0;
            res_y      <= '0;
          end
        end
        S_SCAN, S_DRAIN: begin
          if (xfer) begin
            if (cell_x == LAST_X) begin
              cell_x <= '0;
              cell_y <= cell_last ? '0 : cell_y + 1'b1;
            end else begin
              cell_x <= cell_x + 1'b1;
            end
            if (cell_last) begin
              cell_valid <= 1'b0;
              state      <= S_DRAIN;
            end
          end
          // A zero-latency rule stage can return the last result on the
          // same edge as the last transfer; COMMIT must win in that case.
          if (res_valid) begin
            shadow[res_idx] <= res_alive;
            if (res_x == LAST_X) begin
              res_x <= '0;
              res_y <= res_last ? '0 : res_y + 1'b1;
            end else begin
              res_x <= res_x + 1'b1;
            end
            if (res_last) begin
              cell_valid <= 1'b0;
              state      <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          grid     <= shadow;
          state    <= S_IDLE;
          busy     <= 1'b0;
          gen_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbour_scanner.sv
// Directed bench for neighbour_scanner: blinker, corners (both edge policies),
// backpressure, result lag, protocol misuse and mid-scan reset.
module tb_neighbour_scanner;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       step = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_x = '0;
  logic [3:0] wr_y = '0;
  logic       wr_alive = 1'b0;
  logic [4:0] rd_x = '0;
  logic [3:0] rd_y = '0;
  logic       cell_ready = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_alive = 1'b0;

  logic       rd_alive, cell_valid, cell_alive, busy, gen_done;
  logic [4:0] cell_x;
  logic [3:0] cell_y;
  logic [3:0] sum_neighbours;

  logic       w_rd_alive, w_cell_valid, w_cell_alive, w_busy, w_gen_done;
  logic [4:0] w_cell_x;
  logic [3:0] w_cell_y;
  logic [3:0] w_sum_neighbours;

  int checks = 0;
  int failures = 0;
  int sum_seen[CELLS];
  int w_sum_seen[CELLS];

  neighbour_scanner #(.MAX_I(19), .MAX_J(14), .WRAP(1'b0)) dut (
    .clk(clk), .clr(clr), .step(step), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_alive(wr_alive), .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_x(cell_x), .cell_y(cell_y),
    .cell_alive(cell_alive), .sum_neighbours(sum_neighbours), .res_valid(res_valid),
    .res_alive(res_alive), .busy(busy), .gen_done(gen_done)
  );

  neighbour_scanner #(.MAX_I(19), .MAX_J(14), .WRAP(1'b1)) dut_w (
    .clk(clk), .clr(clr), .step(step), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_alive(wr_alive), .rd_x(rd_x), .rd_y(rd_y), .rd_alive(w_rd_alive),
    .cell_valid(w_cell_valid), .cell_ready(cell_ready), .cell_x(w_cell_x), .cell_y(w_cell_y),
    .cell_alive(w_cell_alive), .sum_neighbours(w_sum_neighbours), .res_valid(res_valid),
    .res_alive(res_alive), .busy(w_busy), .gen_done(w_gen_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int idx(input int x, input int y);
    return y * COLS + x;
  endfunction

  function automatic bit life(input bit a, input int s);
    return (s == 3) || (a && s == 2);
  endfunction

  task automatic wr_cell(input int x, input int y, input bit a);
    wr_x = 5'(x); wr_y = 4'(y); wr_alive = a; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_cell(input int x, input int y, output int v);
    rd_x = 5'(x); rd_y = 4'(y);
    #1 v = int'(rd_alive);
  endtask

  task automatic grid_check(input string tag, input bit [CELLS-1:0] exp);
    int errs = 0;
    for (int i = 0; i < CELLS; i++) begin
      rd_x = 5'(i % COLS); rd_y = 4'(i / COLS);
      #1 if (rd_alive !== exp[i]) errs++;
    end
    check_val(tag, errs, 0);
  endtask

  // Runs one generation acting as the rule stage; poke injects step/wr_en while busy.
  task automatic run_gen(input int ready_pct, input int max_lag, input bit poke);
    int q_rt[$];
    bit q_al[$];
    int xfers = 0, results = 0, gd_count = 0, gd_cycle = -100, last_res = -100;
    int exp_x = 0, exp_y = 0, seq_err = 0, stall_err = 0, next_rt = 0, rt;
    bit prev_stall = 0;
    logic [4:0] px; logic [3:0] py; logic pa; logic [3:0] ps;
    for (int i = 0; i < CELLS; i++) begin sum_seen[i] = -1; w_sum_seen[i] = -1; end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (gen_done) begin gd_count++; gd_cycle = cyc; end
      if (prev_stall && (cell_valid !== 1'b1 || cell_x !== px || cell_y !== py ||
                         cell_alive !== pa || sum_neighbours !== ps)) stall_err++;
      cell_ready = ($urandom_range(99) < ready_pct);
      if (poke && cyc == 5) begin
        step = 1'b1; wr_en = 1'b1; wr_x = 5'd0; wr_y = 4'd0; wr_alive = 1'b1;
      end else begin
        step = 1'b0; wr_en = 1'b0;
      end
      if (cell_valid && cell_ready) begin
        if (int'(cell_x) != exp_x || int'(cell_y) != exp_y) seq_err++;
        if (idx(int'(cell_x), int'(cell_y)) < CELLS) begin
          sum_seen[idx(int'(cell_x), int'(cell_y))] = int'(sum_neighbours);
          w_sum_seen[idx(int'(w_cell_x), int'(w_cell_y))] = int'(w_sum_neighbours);
        end
        rt = cyc + int'($urandom_range(max_lag));
        if (rt < next_rt) rt = next_rt;
        next_rt = rt;
        q_rt.push_back(rt);
        q_al.push_back(life(cell_alive, int'(sum_neighbours)));
        xfers++;
        if (exp_x == COLS - 1) begin exp_x = 0; exp_y++; end else exp_x++;
      end
      prev_stall = cell_valid && !cell_ready;
      px = cell_x; py = cell_y; pa = cell_alive; ps = sum_neighbours;
      res_valid = 1'b0;
      if (q_rt.size() > 0 && q_rt[0] <= cyc) begin
        res_valid = 1'b1;
        res_alive = q_al.pop_front();
        void'(q_rt.pop_front());
        results++;
        last_res = cyc;
      end
      @(negedge clk);
      if (gd_count > 0 && cyc >= gd_cycle + 3) break;
    end
    step = 1'b0; wr_en = 1'b0; cell_ready = 1'b0; res_valid = 1'b0;
    check_val("transfers", xfers, CELLS);
    check_val("results", results, CELLS);
    check_val("order_errors", seq_err, 0);
    check_val("stall_unstable", stall_err, 0);
    check_val("gen_done_count", gd_count, 1);
    check_val("gen_done_delay", gd_cycle - last_res, 2);
    check_val("busy_after_gen", int'(busy), 0);
  endtask

  initial begin
    bit [CELLS-1:0] vert, horz;
    int v;
    vert = '0; vert[idx(6,3)] = 1'b1; vert[idx(6,4)] = 1'b1; vert[idx(6,5)] = 1'b1;
    horz = '0; horz[idx(5,4)] = 1'b1; horz[idx(6,4)] = 1'b1; horz[idx(7,4)] = 1'b1;

    repeat (2) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_cell_valid", int'(cell_valid), 0);
    check_val("rst_gen_done", int'(gen_done), 0);
    check_val("rst_cell_xy", int'(cell_x) + int'(cell_y), 0);
    clr = 1'b1;
    @(negedge clk);
    grid_check("rst_grid", '0);

    // blinker
    wr_cell(5, 4, 1'b1); wr_cell(6, 4, 1'b1); wr_cell(7, 4, 1'b1);
    read_cell(6, 4, v); check_val("seed_6_4", v, 1);
    run_gen(100, 0, 1'b0);
    check_val("sum_6_3", sum_seen[idx(6,3)], 3);
    check_val("sum_6_4", sum_seen[idx(6,4)], 2);
    check_val("sum_5_4", sum_seen[idx(5,4)], 1);
    grid_check("blinker_gen1", vert);

    // out-of-range accesses in IDLE
    wr_cell(25, 3, 1'b1);
    read_cell(5, 4, v); check_val("oor_write_alias", v, 0);
    read_cell(25, 2, v); check_val("rd_x25", v, 0);
    read_cell(26, 2, v); check_val("rd_x26_alias", v, 0);
    read_cell(6, 15, v); check_val("rd_y15", v, 0);
    grid_check("after_oor_write", vert);

    // backpressure plus step/wr_en while busy
    run_gen(30, 0, 1'b1);
    grid_check("blinker_gen2", horz);
    read_cell(0, 0, v); check_val("busy_write_ignored", v, 0);

    // delayed results
    run_gen(100, 20, 1'b0);
    grid_check("blinker_gen3", vert);

    // reset in the middle of a scan
    step = 1'b1; @(negedge clk); step = 1'b0;
    cell_ready = 1'b1; res_valid = 1'b1; res_alive = 1'b1;
    repeat (40) @(negedge clk);
    check_val("midscan_busy", int'(busy), 1);
    cell_ready = 1'b0; res_valid = 1'b0;
    clr = 1'b0;
    #1;
    check_val("clr_busy", int'(busy), 0);
    check_val("clr_cell_valid", int'(cell_valid), 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    grid_check("clr_grid", '0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    check_val("restart_valid", int'(cell_valid), 1);
    check_val("restart_x", int'(cell_x), 0);
    check_val("restart_y", int'(cell_y), 0);
    clr = 1'b0; @(negedge clk); clr = 1'b1; @(negedge clk);

    // corners, both edge policies
    wr_cell(0, 0, 1'b1); wr_cell(19, 0, 1'b1); wr_cell(0, 14, 1'b1); wr_cell(19, 14, 1'b1);
    run_gen(100, 0, 1'b0);
    check_val("nowrap_sum_0_0", sum_seen[idx(0,0)], 0);
    check_val("nowrap_sum_19_14", sum_seen[idx(19,14)], 0);
    check_val("wrap_sum_0_0", w_sum_seen[idx(0,0)], 3);
    check_val("wrap_sum_19_14", w_sum_seen[idx(19,14)], 3);
    check_val("wrap_sum_1_0", w_sum_seen[idx(1,0)], 2);
    grid_check("corners_die", '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
